// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key encoder.
//   frame_st_e : frame receiver states
//   PS2_*      : prefix bytes recognised by the byte decoder
//   KEY_*      : bit positions inside the 11-bit ps2_key event word
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_st_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  // Odd parity over data plus parity bit holds when the total count of ones is odd.
  function automatic logic odd_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_key_encoder_if.sv
// Key-event bus driven by the encoder toward the core's keyboard decoder.
//   ps2_key   : {toggle, pressed, ext, code[7:0]}
//   frame_err : one-cycle pulse on a bad or aborted frame
//   err_cnt   : saturating count of frame_err pulses
interface ps2_key_encoder_if;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic [7:0]  err_cnt;

  modport master (output ps2_key, output frame_err, output err_cnt);
  modport slave  (input  ps2_key, input  frame_err, input  err_cnt);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 serial frame receiver.
//   clk_sys, reset_n   : system clock, async active-low reset
//   ps2_clk, ps2_data  : raw asynchronous pins
//   byte_valid         : one-cycle pulse, rx_byte holds a good byte
//   rx_byte            : received data byte
//   frame_err          : one-cycle pulse on parity/stop/timeout error
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 5040
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_s, dat_s;
  logic          flt;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  // Sync both pins, then require FILTER_LEN consecutive disagreeing samples
  // before the filtered clock moves. Idle bus level is high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s   <= 2'b11;
      dat_s   <= 2'b11;
      flt     <= 1'b1;
      flt_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      fall  <= 1'b0;
      if (clk_s[1] != flt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          flt     <= clk_s[1];
          flt_cnt <= '0;
          fall    <= flt;  // only a 1->0 move is a strobe
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  frame_st_e     st, st_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          par, par_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          bv_n, err_n;
  logic          din;

  assign din     = dat_s[1];
  assign rx_byte = sh;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      st         <= IDLE;
      idx        <= '0;
      sh         <= '0;
      par        <= 1'b0;
      tmo        <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      st         <= st_n;
      idx        <= idx_n;
      sh         <= sh_n;
      par        <= par_n;
      tmo        <= tmo_n;
      byte_valid <= bv_n;
      frame_err  <= err_n;
    end
  end

  always_comb begin
    st_n  = st;
    idx_n = idx;
    sh_n  = sh;
    par_n = par;
    tmo_n = '0;
    bv_n  = 1'b0;
    err_n = 1'b0;
    if (!fall && st != IDLE) tmo_n = tmo + 1'b1;
    case (st)
      IDLE:
        if (fall && !din) begin
          st_n  = DATA;
          idx_n = '0;
        end
      DATA:
        if (fall) begin
          sh_n  = {din, sh[7:1]};  // LSB arrives first
          idx_n = idx + 1'b1;
          if (idx == 3'd7) st_n = PARITY;
        end
      PARITY:
        if (fall) begin
          par_n = din;
          st_n  = STOP;
        end
      STOP:
        if (fall) begin
          st_n = IDLE;
          if (din && odd_ok(sh, par)) bv_n  = 1'b1;
          else                        err_n = 1'b1;
        end
      default: st_n = IDLE;
    endcase
    // Timeout only fires on a non-strobe cycle, so it can never coincide
    // with a stop-bit decision.
    if (st != IDLE && !fall && tmo == TW'(TIMEOUT)) begin
      st_n  = IDLE;
      err_n = 1'b1;
      tmo_n = '0;
    end
  end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to 11-bit toggle-strobe key-event encoder.
//   clk_sys, reset_n  : system clock, async active-low reset
//   ps2_clk, ps2_data : raw PS/2 pins
//   key_if (master)   : ps2_key event word, frame_err pulse, err_cnt
// Holds the prefix decoder (E0 ext, F0 release, E1 pause skip) and error counter.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 5040
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_key_encoder_if.master key_if
);

  logic        byte_valid, frame_err;
  logic [7:0]  rx_byte;
  logic [10:0] key;
  logic        ext, rel;
  logic [2:0]  skip;
  logic [7:0]  errc;

  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key  <= '0;
      ext  <= 1'b0;
      rel  <= 1'b0;
      skip <= '0;
      errc <= '0;
    end else if (frame_err) begin
      // Drop any pending prefix so a later byte is never mis-tagged.
      ext  <= 1'b0;
      rel  <= 1'b0;
      skip <= '0;
      if (errc != 8'hFF) errc <= errc + 1'b1;
    end else if (byte_valid) begin
      if (skip != 3'd0) begin
        skip <= skip - 1'b1;
      end else begin
        case (rx_byte)
          PS2_EXT:   ext  <= 1'b1;
          PS2_BRK:   rel  <= 1'b1;
          PS2_PAUSE: skip <= PAUSE_SKIP;
          default: begin
            key[KEY_TOGGLE]  <= ~key[KEY_TOGGLE];
            key[KEY_PRESSED] <= ~rel;
            key[KEY_EXT]     <= ext;
            key[7:0]         <= rx_byte;
            ext              <= 1'b0;
            rel              <= 1'b0;
          end
        endcase
      end
    end
  end

  assign key_if.ps2_key   = key;
  assign key_if.frame_err = frame_err;
  assign key_if.err_cnt   = errc;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench: expected events are queued as frames are sent and
// popped whenever ps2_key changes.
module tb_ps2_key_encoder;

  localparam int TIMEOUT = 5040;
  localparam int HALF    = 30;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_key_encoder_if key_if ();

  ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_if   (key_if)
  );

  always #20 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  logic [10:0] q[$];
  logic [10:0] prev = '0;
  int err_seen = 0;
  int err_exp  = 0;
  bit tgl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every change of ps2_key must match the head of the queue.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (key_if.ps2_key !== prev) begin
        if (q.size() == 0) chk("unexp_evt", {21'd0, key_if.ps2_key}, {21'd0, prev});
        else               chk("evt", {21'd0, key_if.ps2_key}, {21'd0, q.pop_front()});
      end
      if (key_if.frame_err) err_seen++;
    end
    prev = key_if.ps2_key;
  end

  task automatic wcyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic exp_evt(input bit pressed, input bit ext, input logic [7:0] code);
    tgl = ~tgl;
    q.push_back({tgl, pressed, ext, code});
  endtask

  // Send nbits of a frame (11 = full). bad_par flips parity; glitch adds a
  // short low pulse on ps2_clk during the high phase of bit 3.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch && i == 3) begin
        wcyc(10);
        ps2_clk = 1'b0;
        wcyc(4);
        ps2_clk = 1'b1;
        wcyc(HALF - 14);
      end else begin
        wcyc(HALF);
      end
      ps2_clk = 1'b0;
      wcyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wcyc(2 * HALF);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    wcyc(5);
    chk("rst_key", {21'd0, key_if.ps2_key}, 32'h0);
    chk("rst_ferr", {31'd0, key_if.frame_err}, 32'h0);
    chk("rst_errcnt", {24'd0, key_if.err_cnt}, 32'h0);
    reset_n = 1'b1;
    wcyc(20);

    exp_evt(1, 0, 8'h29); send(8'h29);
    chk("k_29", {21'd0, key_if.ps2_key}, 32'h629);
    chk("noerr_29", err_seen, 0);

    send(8'hF0);
    chk("f0_hold", {21'd0, key_if.ps2_key}, 32'h629);
    exp_evt(0, 0, 8'h29); send(8'h29);
    chk("k_f029", {21'd0, key_if.ps2_key}, 32'h029);

    send(8'hE0); exp_evt(1, 1, 8'h75); send(8'h75);
    chk("k_e075", {21'd0, key_if.ps2_key}, 32'h775);
    send(8'hE0); send(8'hF0); exp_evt(0, 1, 8'h75); send(8'h75);
    chk("k_e0f075", {21'd0, key_if.ps2_key}, 32'h175);

    // Bad parity after E0: error must drop the pending ext flag.
    send(8'hE0);
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    err_exp++;
    chk("par_errcnt", {24'd0, key_if.err_cnt}, 32'd1);
    chk("par_pulses", err_seen, err_exp);
    chk("par_hold", {21'd0, key_if.ps2_key}, 32'h175);
    exp_evt(1, 0, 8'h1C); send(8'h1C);
    chk("k_1c", {21'd0, key_if.ps2_key}, 32'h61C);

    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    chk("pause_hold", {21'd0, key_if.ps2_key}, 32'h61C);
    exp_evt(1, 0, 8'h29); send(8'h29);
    chk("k_pause29", {21'd0, key_if.ps2_key}, 32'h229);

    // Timeout: start + 4 data bits, then the clock stops.
    send_frame(8'h33, 1'b0, 5, 1'b0);
    wcyc(TIMEOUT + 100);
    err_exp++;
    chk("tmo_errcnt", {24'd0, key_if.err_cnt}, 32'd2);
    chk("tmo_pulses", err_seen, err_exp);
    exp_evt(1, 0, 8'h05); send(8'h05);
    chk("k_05", {21'd0, key_if.ps2_key}, 32'h605);

    // Glitch on ps2_clk shorter than the filter.
    exp_evt(1, 0, 8'h5A); send_frame(8'h5A, 1'b0, 11, 1'b1);
    chk("k_glitch", {21'd0, key_if.ps2_key}, 32'h25A);
    chk("glitch_noerr", err_seen, err_exp);

    // Reset in mid-frame.
    chk("q_pre_rst", q.size(), 0);
    send_frame(8'h44, 1'b0, 5, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_key", {21'd0, key_if.ps2_key}, 32'h0);
    chk("midrst_errcnt", {24'd0, key_if.err_cnt}, 32'h0);
    tgl = 1'b0;
    wcyc(3);
    reset_n = 1'b1;
    wcyc(10);
    exp_evt(1, 0, 8'h29); send(8'h29);
    chk("k_postrst", {21'd0, key_if.ps2_key}, 32'h629);
    chk("postrst_errcnt", {24'd0, key_if.err_cnt}, 32'h0);

    wcyc(100);
    chk("q_empty", q.size(), 0);
    chk("err_pulses", err_seen, err_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
